// File: rtl/settings_bus_arbiter_pkg.sv
// Shared definitions for the settings bus arbiter: FSM states, requester IDs, bus widths.
// No logic here; latency and backpressure live in the modules that import it.
package settings_bus_arbiter_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } sba_state_e;

  localparam logic REQ_H = 1'b0;
  localparam logic REQ_S = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sba_wr_t;

  function automatic sba_wr_t sba_pick(input logic sel_s, input sba_wr_t h_wr, input sba_wr_t s_wr);
    return sel_s ? s_wr : h_wr;
  endfunction

endpackage

// File: rtl/sba_lock_timer.sv
// Sequencer lock flag with idle timeout and sticky lock_err; set/clear/timeout take effect next cycle.
// No backpressure: the counter simply holds whenever idle_tick is low.
module sba_lock_timer #(
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic lock_set,
  input  logic lock_clr,
  input  logic idle_tick,
  output logic lock,
  output logic lock_err
);

  logic       lock_q, lock_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    lock_d = lock_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    if (lock_set) begin
      lock_d = 1'b1;
      cnt_d  = '0;
    end else if (lock_clr) begin
      lock_d = 1'b0;
      cnt_d  = '0;
    end else if (idle_tick && lock_q) begin
      // The tick that reaches the limit releases the lock on this edge.
      if (cnt_q == 8'(LOCK_TIMEOUT - 1)) begin
        lock_d = 1'b0;
        err_d  = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      lock_q <= lock_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lock     = lock_q;
  assign lock_err = err_q;

endmodule

// File: rtl/settings_bus_arbiter.sv
// Two-writer arbiter for the serial settings bus (optional SBA_ADDR_GUARD_EN drops host writes at/above GUARD_BASE).
// Ready at N, strobe at N+1, next accept at N+2+GAP_CYCLES; requesters hold valid while ready is low.
module settings_bus_arbiter
  import settings_bus_arbiter_pkg::*;
#(
  parameter int GAP_CYCLES    = 1,
  parameter int HOST_PRIORITY = 0,
  parameter int LOCK_TIMEOUT  = 16
`ifdef SBA_ADDR_GUARD_EN
  ,
  parameter logic [ADDR_W-1:0] GUARD_BASE = 7'd64
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              h_valid,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_data,
  output logic              h_ready,
  input  logic              s_valid,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_lock,
  output logic              s_ready,
  output logic [ADDR_W-1:0] serial_addr,
  output logic [DATA_W-1:0] serial_data,
  output logic              serial_strobe,
  output logic              busy,
  output logic              lock_err,
`ifdef SBA_ADDR_GUARD_EN
  output logic              guard_hit,
`endif
  output logic              last_grant
);

  sba_state_e state_q, state_d;
  logic [3:0] gap_q, gap_d;
  sba_wr_t    wr_q, wr_d;
  logic       strobe_q, strobe_d;
  logic       last_q, last_d;
  logic       rr_s_q, rr_s_d;     // round-robin pointer: 1 = S wins the next tie

  sba_wr_t h_wr, s_wr;
  logic    lock;
  logic    h_elig, s_elig, h_win, can_grant, guarded;

  assign h_wr = {h_addr, h_data};
  assign s_wr = {s_addr, s_data};

  assign h_elig    = h_valid & ~lock;
  assign s_elig    = s_valid;
  assign can_grant = (state_q == IDLE) & enable;

  always_comb begin
    h_win = h_elig;
    if (h_elig && s_elig) h_win = (HOST_PRIORITY != 0) || !rr_s_q;
  end

  assign h_ready = can_grant & h_elig & h_win;
  assign s_ready = can_grant & s_elig & ~h_win;

`ifdef SBA_ADDR_GUARD_EN
  logic guard_q, guard_d;

  assign guarded = h_ready & (h_addr >= GUARD_BASE);
  assign guard_d = guard_q | guarded;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) guard_q <= 1'b0;
    else        guard_q <= guard_d;
  end

  assign guard_hit = guard_q;
`else
  assign guarded = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    wr_d     = wr_q;
    strobe_d = 1'b0;
    last_d   = last_q;
    rr_s_d   = rr_s_q;
    case (state_q)
      IDLE: begin
        if (h_ready || s_ready) begin
          last_d = s_ready ? REQ_S : REQ_H;
          rr_s_d = h_ready;
          gap_d  = '0;
          // A guarded host write still consumes its gap slot but never reaches the bus.
          if (guarded) begin
            state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            wr_d     = sba_pick(s_ready, h_wr, s_wr);
            strobe_d = 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        gap_d   = '0;
        state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_q == 4'(GAP_CYCLES - 1)) state_d = IDLE;
        else                             gap_d   = gap_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      wr_q     <= '0;
      strobe_q <= 1'b0;
      last_q   <= REQ_H;
      rr_s_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      wr_q     <= wr_d;
      strobe_q <= strobe_d;
      last_q   <= last_d;
      rr_s_q   <= rr_s_d;
    end
  end

  // The timer only advances while the arbiter could grant and S is silent.
  sba_lock_timer #(
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_lock_timer (
    .clock    (clock),
    .reset    (reset),
    .lock_set (s_ready & s_lock),
    .lock_clr (s_ready & ~s_lock),
    .idle_tick(can_grant & ~s_valid),
    .lock     (lock),
    .lock_err (lock_err)
  );

  assign serial_addr   = wr_q.addr;
  assign serial_data   = wr_q.data;
  assign serial_strobe = strobe_q;
  assign last_grant    = last_q;
  assign busy          = (state_q != IDLE) | lock;

  a_ready_exclusive: assert property (@(posedge clock) disable iff (!reset) !(h_ready && s_ready));
  a_strobe_single:   assert property (@(posedge clock) disable iff (!reset) serial_strobe |=> !serial_strobe);
  a_lock_blocks_h:   assert property (@(posedge clock) disable iff (!reset) lock |-> !h_ready);

endmodule
